reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 123 ++++++++++++
 tb/tb_reg_file_param.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// reg_file_param: parameterised register file with NUM_RD combinational read
// ports, two write ports, optional write-to-read forwarding, optional
// hardwired-zero entry 0 and a one-entry-per-cycle zeroing sweep.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | normal operation, reads and writes serviced
// S_CLEAR | sweep zeroes entry sweep_idx each cycle; writes dropped,
//         | reads return 0, iClear ignored
module reg_file_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 4,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0
) (
  input  logic                       iClock,
  input  logic                       iReset_n,
  input  logic                       iClear,
  output logic                       oBusy,
  input  logic [NUM_RD-1:0]          iRdEn,
  input  logic [NUM_RD*ADDR_W-1:0]   iRdSel,
  output logic [NUM_RD*DATA_W-1:0]   oRdData,
  input  logic                       iWrEn1,
  input  logic [ADDR_W-1:0]          iWrSel1,
  input  logic [DATA_W-1:0]          iWrData1,
  input  logic                       iWrEn2,
  input  logic [ADDR_W-1:0]          iWrSel2,
  input  logic [DATA_W-1:0]          iWrData2,
  output logic                       oWrCollision
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] SEL_ZERO = '0;
  localparam bit BP_ON = (BYPASS != 0);
  localparam bit ZR_ON = (ZERO_REG0 != 0);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] sweep_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              wr1_go;
  logic              wr2_go;

  assign oBusy = (state == S_CLEAR);

  // A write is accepted only in IDLE and not in the cycle a sweep is requested;
  // entry 0 silently absorbs writes when it is hardwired to zero.
  assign wr_ok  = (state == S_IDLE) && !iClear;
  assign wr1_go = iWrEn1 && wr_ok && !(ZR_ON && (iWrSel1 == SEL_ZERO));
  assign wr2_go = iWrEn2 && wr_ok && !(ZR_ON && (iWrSel2 == SEL_ZERO));

  // Sweep sequencer: start on iClear, walk every entry once, stop at the last.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state     <= S_IDLE;
      sweep_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iClear) begin
            state     <= S_CLEAR;
            sweep_idx <= '0;
          end
        end
        S_CLEAR: begin
          if (sweep_idx == LAST_IDX) begin
            state     <= S_IDLE;
            sweep_idx <= '0;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          sweep_idx <= '0;
        end
      endcase
    end
  end

  // Storage: sweep zeroing, otherwise both write ports with port 2 last so it wins.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == S_CLEAR) begin
      mem[sweep_idx] <= '0;
    end else begin
      if (wr1_go) mem[iWrSel1] <= iWrData1;
      if (wr2_go) mem[iWrSel2] <= iWrData2;
    end
  end

  // Collision flag covers only writes that were actually accepted.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) oWrCollision <= 1'b0;
    else           oWrCollision <= wr1_go && wr2_go && (iWrSel1 == iWrSel2);
  end

  // Combinational reads with optional forwarding; reset and sweep force zeros.
  always_comb begin
    logic [ADDR_W-1:0] rsel;
    logic [DATA_W-1:0] rval;
    oRdData = '0;
    rsel    = '0;
    rval    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rsel = iRdSel[k*ADDR_W +: ADDR_W];
      rval = mem[rsel];
      if (BP_ON) begin
        if (wr1_go && (iWrSel1 == rsel)) rval = iWrData1;
        if (wr2_go && (iWrSel2 == rsel)) rval = iWrData2;
      end
      if (iReset_n && !oBusy && iRdEn[k] && !(ZR_ON && (rsel == SEL_ZERO)))
        oRdData[k*DATA_W +: DATA_W] = rval;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: three instances (default, no forwarding,
// hardwired entry 0) share one stimulus and are checked every cycle against
// an array model, plus literal checks at key points.
module tb_reg_file_param;

  logic        iClock = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iClear = 1'b0;
  logic [3:0]  rd_en = 4'hF;
  logic [19:0] rd_sel = '0;
  logic        we1 = 1'b0, we2 = 1'b0;
  logic [4:0]  ws1 = '0, ws2 = '0;
  logic [15:0] wd1 = '0, wd2 = '0;
  logic [63:0] rd_data [3];
  logic [2:0]  busy, coll;

  int n_cmp = 0;
  int n_err = 0;

  // Model: entry arrays per instance, remaining busy cycles, expected collision.
  bit [15:0] mm [3][32];
  int        sweep_left = 0;
  bit [2:0]  m_coll = '0;

  always #5 iClock = ~iClock;

  reg_file_param u0 (
    .iClock(iClock), .iReset_n(iReset_n), .iClear(iClear), .oBusy(busy[0]),
    .iRdEn(rd_en), .iRdSel(rd_sel), .oRdData(rd_data[0]),
    .iWrEn1(we1), .iWrSel1(ws1), .iWrData1(wd1),
    .iWrEn2(we2), .iWrSel2(ws2), .iWrData2(wd2), .oWrCollision(coll[0]));

  reg_file_param #(.BYPASS(0)) u1 (
    .iClock(iClock), .iReset_n(iReset_n), .iClear(iClear), .oBusy(busy[1]),
    .iRdEn(rd_en), .iRdSel(rd_sel), .oRdData(rd_data[1]),
    .iWrEn1(we1), .iWrSel1(ws1), .iWrData1(wd1),
    .iWrEn2(we2), .iWrSel2(ws2), .iWrData2(wd2), .oWrCollision(coll[1]));

  reg_file_param #(.ZERO_REG0(1)) u2 (
    .iClock(iClock), .iReset_n(iReset_n), .iClear(iClear), .oBusy(busy[2]),
    .iRdEn(rd_en), .iRdSel(rd_sel), .oRdData(rd_data[2]),
    .iWrEn1(we1), .iWrSel1(ws1), .iWrData1(wd1),
    .iWrEn2(we2), .iWrSel2(ws2), .iWrData2(wd2), .oWrCollision(coll[2]));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Instance p accepts a write from a port this cycle?
  function automatic bit go(int p, logic en, logic [4:0] s);
    return en && (sweep_left == 0) && !iClear && !(p == 2 && s == 5'd0);
  endfunction

  function automatic logic [15:0] exp_rd(int p, int k);
    logic [4:0] s;
    if (!iReset_n || sweep_left != 0 || !rd_en[k]) return 16'h0000;
    s = rd_sel[k*5 +: 5];
    if (p == 2 && s == 5'd0) return 16'h0000;
    if (p != 1) begin
      if (go(p, we2, ws2) && ws2 == s) return wd2;
      if (go(p, we1, ws1) && ws1 == s) return wd1;
    end
    return mm[p][s];
  endfunction

  function automatic logic [15:0] rdp(int p, int k);
    return rd_data[p][k*16 +: 16];
  endfunction

  // Model state advance: a sweep simply blanks everything and blocks 32 cycles.
  always @(posedge iClock) begin
    if (iReset_n) begin
      if (sweep_left > 0) begin
        sweep_left = sweep_left - 1;
        m_coll = '0;
      end else if (iClear) begin
        sweep_left = 32;
        m_coll = '0;
        for (int p = 0; p < 3; p++) for (int i = 0; i < 32; i++) mm[p][i] = '0;
      end else begin
        for (int p = 0; p < 3; p++) begin
          bit g1, g2;
          g1 = go(p, we1, ws1);
          g2 = go(p, we2, ws2);
          if (g1) mm[p][ws1] = wd1;
          if (g2) mm[p][ws2] = wd2;
          m_coll[p] = g1 && g2 && (ws1 == ws2);
        end
      end
    end
  end

  always @(negedge iReset_n) begin
    sweep_left = 0;
    m_coll = '0;
    for (int p = 0; p < 3; p++) for (int i = 0; i < 32; i++) mm[p][i] = '0;
  end

  // Per-cycle compare of every output of every instance against the model.
  always @(negedge iClock) begin
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("u%0d_busy", p), {15'd0, busy[p]}, {15'd0, (sweep_left != 0) && iReset_n});
      chk($sformatf("u%0d_coll", p), {15'd0, coll[p]}, {15'd0, m_coll[p] && iReset_n});
      for (int k = 0; k < 4; k++)
        chk($sformatf("u%0d_rd%0d", p, k), rdp(p, k), exp_rd(p, k));
    end
  end

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic set_sel(int k, logic [4:0] s);
    rd_sel[k*5 +: 5] = s;
  endtask

  task automatic no_wr();
    we1 = 1'b0;
    we2 = 1'b0;
  endtask

  initial begin
    int cnt;
    repeat (3) @(posedge iClock);
    #1;
    chk("rst_busy", {15'd0, busy[0]}, 16'd0);
    chk("rst_rd0", rdp(0, 0), 16'h0000);
    chk("rst_coll", {15'd0, coll[0]}, 16'd0);
    iReset_n = 1'b1;
    we1 = 1'b1; ws1 = 5'd2; wd1 = 16'h2222;
    step();
    no_wr();

    // single write then read on port 3
    we1 = 1'b1; ws1 = 5'd7; wd1 = 16'hA5A5; rd_en = 4'b0000;
    step();
    no_wr(); rd_en = 4'b1000; set_sel(3, 5'd7);
    #1;
    chk("wr_rd_p3", rdp(0, 3), 16'hA5A5);
    chk("disabled_p0", rdp(0, 0), 16'h0000);
    chk("disabled_p1", rdp(0, 1), 16'h0000);

    // forwarding vs none
    step();
    rd_en = 4'b0001; set_sel(0, 5'd3);
    we1 = 1'b1; ws1 = 5'd3; wd1 = 16'h1234;
    #1;
    chk("bypass_on", rdp(0, 0), 16'h1234);
    chk("bypass_off", rdp(1, 0), 16'h0000);
    step();
    no_wr();
    #1;
    chk("bypass_off_next", rdp(1, 0), 16'h1234);

    // same-address collision
    step();
    we1 = 1'b1; ws1 = 5'd9; wd1 = 16'h1111;
    we2 = 1'b1; ws2 = 5'd9; wd2 = 16'h2222;
    set_sel(0, 5'd9);
    step();
    no_wr();
    #1;
    chk("coll_set", {15'd0, coll[0]}, 16'd1);
    chk("coll_port2_wins", rdp(0, 0), 16'h2222);
    step();
    #1;
    chk("coll_one_cycle", {15'd0, coll[0]}, 16'd0);

    // different addresses in one cycle
    we1 = 1'b1; ws1 = 5'd9;  wd1 = 16'h0909;
    we2 = 1'b1; ws2 = 5'd10; wd2 = 16'h1010;
    step();
    no_wr(); rd_en = 4'b0011; set_sel(0, 5'd9); set_sel(1, 5'd10);
    #1;
    chk("dual_no_coll", {15'd0, coll[0]}, 16'd0);
    chk("dual_e9", rdp(0, 0), 16'h0909);
    chk("dual_e10", rdp(0, 1), 16'h1010);

    // forwarding priority when both ports hit the read address
    step();
    we1 = 1'b1; ws1 = 5'd5; wd1 = 16'h5151;
    we2 = 1'b1; ws2 = 5'd5; wd2 = 16'h5252;
    rd_en = 4'b0111; set_sel(2, 5'd5);
    #1;
    chk("fwd_prio_p2", rdp(0, 2), 16'h5252);
    chk("fwd_off_prior", rdp(1, 2), 16'h0000);
    step();
    no_wr();

    // hardwired entry 0
    we1 = 1'b1; ws1 = 5'd0; wd1 = 16'hFFFF;
    we2 = 1'b1; ws2 = 5'd0; wd2 = 16'hFFFF;
    rd_en = 4'b0001; set_sel(0, 5'd0);
    #1;
    chk("z0_fwd", rdp(2, 0), 16'h0000);
    chk("nz0_fwd", rdp(0, 0), 16'hFFFF);
    step();
    no_wr();
    #1;
    chk("z0_coll", {15'd0, coll[2]}, 16'd0);
    chk("nz0_coll", {15'd0, coll[0]}, 16'd1);
    chk("z0_rd", rdp(2, 0), 16'h0000);

    // fill all entries, then sweep
    rd_en = 4'hF;
    for (int i = 0; i < 16; i++) begin
      we1 = 1'b1; ws1 = 5'(i);      wd1 = 16'h0100 + 16'(i);
      we2 = 1'b1; ws2 = 5'(i + 16); wd2 = 16'h0200 + 16'(i);
      step();
    end
    no_wr(); set_sel(0, 5'd31); set_sel(1, 5'd1);
    #1;
    chk("fill_e31", rdp(0, 0), 16'h020F);
    chk("fill_e1", rdp(0, 1), 16'h0101);
    iClear = 1'b1;
    we1 = 1'b1; ws1 = 5'd4; wd1 = 16'hBEEF;
    we2 = 1'b1; ws2 = 5'd4; wd2 = 16'hBEEF;
    step();
    iClear = 1'b0; we2 = 1'b0; ws1 = 5'd1; wd1 = 16'hDEAD;
    #1;
    chk("sweep_busy", {15'd0, busy[0]}, 16'd1);
    chk("clr_cycle_drop_coll", {15'd0, coll[0]}, 16'd0);
    chk("sweep_rd", rdp(0, 1), 16'h0000);
    cnt = 0;
    while (busy[0] === 1'b1 && cnt < 100) begin
      iClear = (cnt == 5);
      step();
      cnt++;
    end
    iClear = 1'b0; no_wr();
    chk("busy_len", 16'(cnt), 16'd32);
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 4; k++) set_sel(k, 5'(j*4 + k));
      #1;
      for (int k = 0; k < 4; k++) chk($sformatf("post_sweep_e%0d", j*4 + k), rdp(0, k), 16'h0000);
      step();
    end

    // reset mid-sweep
    we1 = 1'b1; ws1 = 5'd12; wd1 = 16'hC0C0;
    we2 = 1'b1; ws2 = 5'd20; wd2 = 16'h2020;
    step();
    no_wr();
    iClear = 1'b1;
    step();
    iClear = 1'b0;
    set_sel(0, 5'd12); set_sel(1, 5'd20);
    repeat (12) step();
    #1 iReset_n = 1'b0;
    #1;
    chk("abort_busy", {15'd0, busy[0]}, 16'd0);
    chk("abort_rd", rdp(0, 0), 16'h0000);
    step();
    step();
    iReset_n = 1'b1;
    step();
    #1;
    chk("after_rst_busy", {15'd0, busy[0]}, 16'd0);
    chk("after_rst_e12", rdp(0, 0), 16'h0000);
    chk("after_rst_e20", rdp(0, 1), 16'h0000);
    we1 = 1'b1; ws1 = 5'd3; wd1 = 16'h3333;
    step();
    no_wr(); set_sel(0, 5'd3);
    #1;
    chk("after_rst_idle_wr", rdp(0, 0), 16'h3333);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
